// File: rtl/conv_stream_engine_if.sv
// conv_stream_engine_if: operand-fetch and result-stream bundle for conv_stream_engine.
//   fm_rd_en/fm_addr -> fm_rd_data : feature-map read port, data returned one cycle later
//   kw_rd_en/kw_addr -> kw_rd_data : kernel read port, data returned one cycle later
//   out_valid/out_ready/out_data/out_row/out_col : result pixel stream
// master = engine side, slave = buffer/consumer side.
interface conv_stream_engine_if #(
  parameter int unsigned DW    = 16,
  parameter int unsigned FM_AW = 17,
  parameter int unsigned KW_AW = 12,
  parameter int unsigned ROW_W = 5,
  parameter int unsigned COL_W = 5
);
  logic             fm_rd_en;
  logic [FM_AW-1:0] fm_addr;
  logic [DW-1:0]    fm_rd_data;
  logic             kw_rd_en;
  logic [KW_AW-1:0] kw_addr;
  logic [DW-1:0]    kw_rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;

  modport master (
    output fm_rd_en, fm_addr, kw_rd_en, kw_addr, out_valid, out_data, out_row, out_col,
    input  fm_rd_data, kw_rd_data, out_ready
  );

  modport slave (
    input  fm_rd_en, fm_addr, kw_rd_en, kw_addr, out_valid, out_data, out_row, out_col,
    output fm_rd_data, kw_rd_data, out_ready
  );
endinterface

// File: rtl/conv_stream_engine.sv
// conv_stream_engine: sequential 2-D multi-channel convolution, one MAC per cycle,
// one output pixel at a time with zero padding, stride, round/saturate and optional ReLU.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   start   : begin a frame (sampled only when idle)
//   relu_en : clamp negative results to zero, captured at start
//   busy    : frame in progress
//   done    : one-cycle pulse after the final pixel is accepted
//   bus     : master side of conv_stream_engine_if (operand reads + result stream)
module conv_stream_engine #(
  parameter int unsigned IN_H   = 27,
  parameter int unsigned IN_W   = 27,
  parameter int unsigned CH     = 96,
  parameter int unsigned K      = 5,
  parameter int unsigned PAD    = 2,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned DW     = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned ACC_W  = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic relu_en,
  output logic busy,
  output logic done,
  conv_stream_engine_if.master bus
);

  localparam int unsigned OUT_H = (IN_H + 2 * PAD - K) / STRIDE + 1;
  localparam int unsigned OUT_W = (IN_W + 2 * PAD - K) / STRIDE + 1;
  localparam int unsigned FM_AW = $clog2(IN_H * IN_W * CH);
  localparam int unsigned KW_AW = $clog2(K * K * CH);
  localparam int unsigned ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned KIW   = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned CIW   = (CH > 1) ? $clog2(CH) : 1;

  localparam logic signed [ACC_W-1:0] RoundBias = ACC_W'(64'sd1 <<< (FRAC - 1));
  localparam logic signed [ACC_W-1:0] SatMax    = ACC_W'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SatMin    = ~SatMax;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StOut} state_e;

  state_e                   state_q;
  logic [KIW-1:0]           m_q, n_q;        // next tap to issue
  logic [CIW-1:0]           c_q;
  logic                     last_tap_q;      // tap currently on the read ports is the last one
  logic [ROW_W-1:0]         oy_q;            // pixel being computed
  logic [COL_W-1:0]         ox_q;
  logic                     last_pix_q;      // pixel on the output stream is the last one
  logic                     relu_q;
  logic                     busy_q, done_q;
  logic                     fm_rd_en_q, kw_rd_en_q;
  logic                     rd_pend_q;       // read data arriving this cycle belongs to a tap
  logic [FM_AW-1:0]         fm_addr_q;
  logic [KW_AW-1:0]         kw_addr_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     out_valid_q;
  logic [DW-1:0]            out_data_q;
  logic [ROW_W-1:0]         out_row_q;
  logic [COL_W-1:0]         out_col_q;

  // Tap address generation for the tap pointed to by m_q/n_q/c_q.
  int                       iy, ix;
  logic                     tap_inb, tap_last, issue;
  logic [FM_AW-1:0]         fm_addr_c;
  logic [KW_AW-1:0]         kw_addr_c;
  logic [KIW-1:0]           m_nxt, n_nxt;
  logic [CIW-1:0]           c_nxt;

  always_comb begin
    iy        = int'(oy_q) * int'(STRIDE) + int'(m_q) - int'(PAD);
    ix        = int'(ox_q) * int'(STRIDE) + int'(n_q) - int'(PAD);
    tap_inb   = (iy >= 0) && (iy < int'(IN_H)) && (ix >= 0) && (ix < int'(IN_W));
    fm_addr_c = FM_AW'((iy * int'(IN_W) + ix) * int'(CH) + int'(c_q));
    kw_addr_c = KW_AW'((int'(m_q) * int'(K) + int'(n_q)) * int'(CH) + int'(c_q));
    tap_last  = (m_q == KIW'(K - 1)) && (n_q == KIW'(K - 1)) && (c_q == CIW'(CH - 1));
    c_nxt     = c_q + 1'b1;
    n_nxt     = n_q;
    m_nxt     = m_q;
    if (c_q == CIW'(CH - 1)) begin
      c_nxt = '0;
      if (n_q == KIW'(K - 1)) begin
        n_nxt = '0;
        m_nxt = (m_q == KIW'(K - 1)) ? '0 : m_q + 1'b1;
      end else begin
        n_nxt = n_q + 1'b1;
      end
    end
    issue = ((state_q == StIdle) && start) ||
            ((state_q == StRun) && !last_tap_q) ||
            ((state_q == StOut) && bus.out_ready && !last_pix_q);
  end

  // MAC datapath and result formatting.
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext, acc_sum, acc_rnd, shifted;
  logic [DW-1:0]           out_c;

  always_comb begin
    prod     = $signed(bus.fm_rd_data) * $signed(bus.kw_rd_data);
    prod_ext = {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};
    acc_sum  = rd_pend_q ? acc_q + prod_ext : acc_q;
    acc_rnd  = acc_sum + RoundBias;
    shifted  = acc_rnd >>> FRAC;
    if (relu_q && shifted[ACC_W-1]) begin
      out_c = '0;
    end else if (shifted > SatMax) begin
      out_c = {1'b0, {(DW - 1){1'b1}}};
    end else if (shifted < SatMin) begin
      out_c = {1'b1, {(DW - 1){1'b0}}};
    end else begin
      out_c = shifted[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      m_q         <= '0;
      n_q         <= '0;
      c_q         <= '0;
      last_tap_q  <= 1'b0;
      oy_q        <= '0;
      ox_q        <= '0;
      last_pix_q  <= 1'b0;
      relu_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fm_rd_en_q  <= 1'b0;
      kw_rd_en_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      fm_addr_q   <= '0;
      kw_addr_q   <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      rd_pend_q <= fm_rd_en_q;

      // Out-of-bounds taps keep both strobes low but still consume a cycle.
      if (issue) begin
        fm_rd_en_q <= tap_inb;
        kw_rd_en_q <= tap_inb;
        fm_addr_q  <= fm_addr_c;
        kw_addr_q  <= kw_addr_c;
        m_q        <= m_nxt;
        n_q        <= n_nxt;
        c_q        <= c_nxt;
        last_tap_q <= tap_last;
      end else begin
        fm_rd_en_q <= 1'b0;
        kw_rd_en_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_q  <= 1'b1;
            relu_q  <= relu_en;
            acc_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (rd_pend_q) acc_q <= acc_sum;
          if (last_tap_q) state_q <= StDrain;
        end
        StDrain: begin
          // Last product is folded in combinationally on its way to the output register.
          out_data_q  <= out_c;
          out_row_q   <= oy_q;
          out_col_q   <= ox_q;
          out_valid_q <= 1'b1;
          if (ox_q == COL_W'(OUT_W - 1)) begin
            ox_q <= '0;
            if (oy_q == ROW_W'(OUT_H - 1)) begin
              oy_q       <= '0;
              last_pix_q <= 1'b1;
            end else begin
              oy_q       <= oy_q + 1'b1;
              last_pix_q <= 1'b0;
            end
          end else begin
            ox_q       <= ox_q + 1'b1;
            last_pix_q <= 1'b0;
          end
          state_q <= StOut;
        end
        StOut: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (last_pix_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              acc_q   <= '0;
              state_q <= StRun;
            end
          end
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.fm_rd_en  = fm_rd_en_q;
  assign bus.fm_addr   = fm_addr_q;
  assign bus.kw_rd_en  = kw_rd_en_q;
  assign bus.kw_addr   = kw_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Testbench for conv_stream_engine: two configurations (3x3x2 K3 pad1 stride1, and
// 5x5x1 K3 pad0 stride2), buffer models with one-cycle read latency, and a
// loop-based reference convolution.
module tb_conv_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, relu_a, busy_a, done_a;
  logic start_b, relu_b, busy_b, done_b;

  conv_stream_engine_if #(.DW(16), .FM_AW(5), .KW_AW(5), .ROW_W(2), .COL_W(2)) bus_a ();
  conv_stream_engine_if #(.DW(16), .FM_AW(5), .KW_AW(4), .ROW_W(1), .COL_W(1)) bus_b ();

  conv_stream_engine #(
    .IN_H(3), .IN_W(3), .CH(2), .K(3), .PAD(1), .STRIDE(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .relu_en(relu_a),
    .busy(busy_a), .done(done_a), .bus(bus_a)
  );

  conv_stream_engine #(
    .IN_H(5), .IN_W(5), .CH(1), .K(3), .PAD(0), .STRIDE(2)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .relu_en(relu_b),
    .busy(busy_b), .done(done_b), .bus(bus_b)
  );

  logic [15:0] fm_a [32];
  logic [15:0] kw_a [32];
  logic [15:0] fm_b [32];
  logic [15:0] kw_b [16];

  always @(posedge clk) begin
    if (bus_a.fm_rd_en) bus_a.fm_rd_data <= fm_a[bus_a.fm_addr];
    if (bus_a.kw_rd_en) bus_a.kw_rd_data <= kw_a[bus_a.kw_addr];
    if (bus_b.fm_rd_en) bus_b.fm_rd_data <= fm_b[bus_b.fm_addr];
    if (bus_b.kw_rd_en) bus_b.kw_rd_data <= kw_b[bus_b.kw_addr];
  end

  int tests = 0;
  int fails = 0;
  logic [15:0] qd_a[$];
  int          qr_a[$];
  int          qc_a[$];
  logic [15:0] ref_d[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd_sat(input longint acc, input bit relu);
    longint r;
    r = (acc + 128) >>> 8;
    if (relu && r < 0) r = 0;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic logic [15:0] model_a(input int oy, input int ox, input bit relu);
    longint acc = 0;
    for (int m = 0; m < 3; m++)
      for (int n = 0; n < 3; n++)
        for (int c = 0; c < 2; c++) begin
          int iy = oy + m - 1;
          int ix = ox + n - 1;
          if (iy >= 0 && iy < 3 && ix >= 0 && ix < 3)
            acc += longint'($signed(fm_a[(iy * 3 + ix) * 2 + c])) *
                   longint'($signed(kw_a[(m * 3 + n) * 2 + c]));
        end
    return rnd_sat(acc, relu);
  endfunction

  function automatic logic [15:0] model_b(input int oy, input int ox);
    longint acc = 0;
    for (int m = 0; m < 3; m++)
      for (int n = 0; n < 3; n++)
        acc += longint'($signed(fm_b[(oy * 2 + m) * 5 + ox * 2 + n])) *
               longint'($signed(kw_b[m * 3 + n]));
    return rnd_sat(acc, 1'b0);
  endfunction

  task automatic fill_a(input logic [15:0] fv, input logic [15:0] kv);
    for (int i = 0; i < 32; i++) begin
      fm_a[i] = fv;
      kw_a[i] = kv;
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk(tag, {busy_a, done_a, bus_a.fm_rd_en, bus_a.kw_rd_en, bus_a.out_valid, bus_a.fm_addr,
              bus_a.kw_addr, bus_a.out_data, bus_a.out_row, bus_a.out_col}, 64'd0);
  endtask

  // Runs one frame on instance A; extra_start pulses start mid-frame at that cycle.
  task automatic run_a(input bit relu, input int stall_pct, input int extra_start,
                       output int first_cyc, output int n_done);
    int cyc, end_cyc, tap_stall, oob;
    bit prev_stall, rdy;
    logic [15:0] pd;
    logic [3:0]  ppos;
    qd_a.delete();
    qr_a.delete();
    qc_a.delete();
    first_cyc = -1; n_done = 0; tap_stall = 0; oob = 0; prev_stall = 0; pd = '0; ppos = '0;
    relu_a = relu;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 1;
    end_cyc = 2000;
    chk("busy_rise", busy_a, 1);
    while (cyc < end_cyc) begin
      rdy = ($urandom_range(0, 99) >= stall_pct);
      bus_a.out_ready = rdy;
      start_a = (cyc == extra_start);
      if (cyc == 5) relu_a = ~relu;
      if (prev_stall) begin
        chk("stall_valid", bus_a.out_valid, 1);
        chk("stall_data", bus_a.out_data, pd);
        chk("stall_pos", {bus_a.out_row, bus_a.out_col}, ppos);
      end
      if (bus_a.out_valid && (bus_a.fm_rd_en || bus_a.kw_rd_en)) tap_stall++;
      if ((bus_a.fm_rd_en && bus_a.fm_addr >= 5'd18) ||
          (bus_a.kw_rd_en && bus_a.kw_addr >= 5'd18)) oob++;
      if (bus_a.out_valid && first_cyc < 0) first_cyc = cyc;
      if (bus_a.out_valid && rdy) begin
        qd_a.push_back(bus_a.out_data);
        qr_a.push_back(int'(bus_a.out_row));
        qc_a.push_back(int'(bus_a.out_col));
      end
      if (done_a) begin
        n_done++;
        chk("busy_at_done", busy_a, 0);
        if (n_done == 1) end_cyc = cyc + 4;
      end
      prev_stall = bus_a.out_valid && !rdy;
      pd = bus_a.out_data;
      ppos = {bus_a.out_row, bus_a.out_col};
      tick();
      cyc++;
    end
    start_a = 1'b0;
    bus_a.out_ready = 1'b0;
    chk("done_once", n_done, 1);
    chk("no_tap_in_stall", tap_stall, 0);
    chk("oob_a", oob, 0);
  endtask

  task automatic check_frame_a(input string tag, input bit relu);
    chk({tag, "_count"}, qd_a.size(), 9);
    for (int i = 0; i < qd_a.size() && i < 9; i++)
      chk(tag, {8'(qr_a[i]), 8'(qc_a[i]), qd_a[i]},
          {8'(i / 3), 8'(i % 3), model_a(i / 3, i % 3, relu)});
  endtask

  int first_cyc, n_done, seen, n_rd, oob_b, cyc;
  logic [15:0] qd_b[$];
  int          qp_b[$];

  initial begin
    rst = 1'b1;
    start_a = 1'b0; relu_a = 1'b0; start_b = 1'b0; relu_b = 1'b0;
    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b0;
    fill_a(16'h0100, 16'h0100);
    repeat (3) tick();
    chk_reset_a("reset_state_a");
    chk("reset_state_b", {busy_b, done_b, bus_b.out_valid, bus_b.fm_rd_en, bus_b.out_data}, 0);
    rst = 1'b0;
    tick();

    // All ones: corner/edge/centre pixel sums and latency.
    run_a(1'b0, 0, -1, first_cyc, n_done);
    chk("first_valid_cycle", first_cyc, 20);
    chk("px00_ones", qd_a[0], 16'h0800);
    chk("px01_ones", qd_a[1], 16'h0C00);
    chk("px11_ones", qd_a[4], 16'h1200);
    check_frame_a("frame_ones", 1'b0);

    // Negative kernels, with and without ReLU.
    fill_a(16'h0100, 16'hFF00);
    run_a(1'b0, 0, -1, first_cyc, n_done);
    chk("px11_neg", qd_a[4], 16'hEE00);
    check_frame_a("frame_neg", 1'b0);
    run_a(1'b1, 0, -1, first_cyc, n_done);
    chk("relu_count", qd_a.size(), 9);
    for (int i = 0; i < qd_a.size(); i++) chk("relu_zero", qd_a[i], 16'h0000);

    // Saturation both ways.
    fill_a(16'h7FFF, 16'h7FFF);
    run_a(1'b0, 0, -1, first_cyc, n_done);
    chk("sat_pos", qd_a[4], 16'h7FFF);
    fill_a(16'h7FFF, 16'h8000);
    run_a(1'b0, 0, -1, first_cyc, n_done);
    chk("sat_neg", qd_a[4], 16'h8000);

    // Random operands, free-running vs 30% backpressure.
    for (int i = 0; i < 32; i++) begin
      fm_a[i] = 16'($urandom);
      kw_a[i] = 16'($urandom);
    end
    run_a(1'b0, 0, -1, first_cyc, n_done);
    check_frame_a("rand_free", 1'b0);
    ref_d = qd_a;
    run_a(1'b0, 30, -1, first_cyc, n_done);
    check_frame_a("rand_bp", 1'b0);
    chk("bp_vs_free_count", qd_a.size(), ref_d.size());
    for (int i = 0; i < qd_a.size() && i < ref_d.size(); i++)
      chk("bp_vs_free", qd_a[i], ref_d[i]);

    // Reset mid-pixel, then a clean frame with a start pulse while busy.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_a("midframe_reset");
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_a || busy_a || bus_a.fm_rd_en) seen++;
      tick();
    end
    chk("no_done_after_reset", seen, 0);
    run_a(1'b1, 30, 30, first_cyc, n_done);
    check_frame_a("after_reset", 1'b1);

    // Instance B: stride 2, no padding, inputs = address.
    for (int i = 0; i < 32; i++) fm_b[i] = (i < 25) ? 16'(i * 256) : 16'h0;
    for (int i = 0; i < 16; i++) kw_b[i] = 16'h0100;
    bus_b.out_ready = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n_done = 0; n_rd = 0; oob_b = 0; cyc = 1;
    while (cyc < 300 && n_done == 0) begin
      if (bus_b.fm_rd_en) begin
        n_rd++;
        if (bus_b.fm_addr >= 5'd25 || bus_b.kw_addr >= 4'd9) oob_b++;
      end
      if (bus_b.out_valid) begin
        qd_b.push_back(bus_b.out_data);
        qp_b.push_back(int'({bus_b.out_row, bus_b.out_col}));
      end
      if (done_b) n_done++;
      tick();
      cyc++;
    end
    chk("b_done", n_done, 1);
    chk("b_count", qd_b.size(), 4);
    chk("b_px00", qd_b[0], 16'h3600);
    for (int i = 0; i < qd_b.size() && i < 4; i++) begin
      chk("b_order", qp_b[i], i);
      chk("b_data", qd_b[i], model_b(i / 2, i % 2));
    end
    chk("b_reads", n_rd, 36);
    chk("b_oob", oob_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
